// File: rtl/write_buffer_responder_pkg.sv
// Shared definitions for the write-buffer handshake: FSM encoding and the word
// width agreed between the write-buffer controller and this responder.
package write_buffer_responder_pkg;

  localparam int WB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    WAIT_DATA = 2'd2
  } wb_state_t;

endpackage

// File: rtl/write_buffer_responder_if.sv
// Producer/consumer bus of the write-buffer responder. The master modport is the
// producer plus consumer side; the slave modport is the responder.
interface write_buffer_responder_if #(
  parameter int DATA_W = write_buffer_responder_pkg::WB_DATA_W,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic              write_req;
  logic              write_in_buffer;
  logic [DATA_W-1:0] wr_data;
  logic              ready;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              protocol_err;
  logic              underflow_err;

  modport master (
    output write_req, write_in_buffer, wr_data, rd_en,
    input  ready, rd_data, empty, full, count, protocol_err, underflow_err
  );

  modport slave (
    input  write_req, write_in_buffer, wr_data, rd_en,
    output ready, rd_data, empty, full, count, protocol_err, underflow_err
  );
endinterface

// File: rtl/write_buffer_responder_sync_fifo.sv
// Show-ahead FIFO with occupancy count and sticky underflow flag; full/empty
// come from the count so pointer equality never has to be disambiguated.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_empty,
  output logic              o_full,
  output logic [ADDR_W:0]   o_count,
  output logic              o_underflow
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_underflow;
  logic              w_push;
  logic              w_pop;

  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == (ADDR_W+1)'(DEPTH));
  assign o_count     = r_count;
  assign o_underflow = r_underflow;
  assign o_rdata     = r_mem[r_rd_ptr];
  assign w_push      = i_push && !o_full;
  assign w_pop       = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else if (i_clr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_pop && o_empty) r_underflow <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/write_buffer_responder.sv
// Responder side of the write-request handshake: grants one write slot at a time,
// captures the strobed word into a FIFO and flags protocol violations.
module write_buffer_responder
  import write_buffer_responder_pkg::*;
#(
  parameter int DATA_W  = WB_DATA_W,
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inner_rst,
  write_buffer_responder_if.slave bus
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  wb_state_t         r_state;
  logic              r_ready;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_protocol_err;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic              w_underflow;
  logic [ADDR_W:0]   w_count;
  logic [DATA_W-1:0] w_rd_data;

  assign w_push = (r_state == WAIT_DATA) && bus.write_in_buffer;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_ready        <= 1'b0;
      r_to_cnt       <= '0;
      r_protocol_err <= 1'b0;
    end else if (inner_rst) begin
      r_state        <= IDLE;
      r_ready        <= 1'b0;
      r_to_cnt       <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      if (bus.write_in_buffer && (r_state != WAIT_DATA)) r_protocol_err <= 1'b1;
      case (r_state)
        IDLE: begin
          if (bus.write_req && !w_full) begin
            r_state <= GRANT;
            r_ready <= 1'b1;
          end
        end
        GRANT: begin
          r_state  <= WAIT_DATA;
          r_ready  <= 1'b1;
          r_to_cnt <= '0;
        end
        WAIT_DATA: begin
          // A strobe on the timeout edge still lands; the data arrived in time.
          if (bus.write_in_buffer) begin
            r_state  <= IDLE;
            r_ready  <= 1'b0;
            r_to_cnt <= '0;
          end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
            r_state        <= IDLE;
            r_ready        <= 1'b0;
            r_to_cnt       <= '0;
            r_protocol_err <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .i_clk       (clk),
    .i_rst_n     (rst),
    .i_clr       (inner_rst),
    .i_push      (w_push),
    .i_wdata     (bus.wr_data),
    .i_pop       (bus.rd_en),
    .o_rdata     (w_rd_data),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_count     (w_count),
    .o_underflow (w_underflow)
  );

  assign bus.ready         = r_ready;
  assign bus.rd_data       = w_rd_data;
  assign bus.empty         = w_empty;
  assign bus.full          = w_full;
  assign bus.count         = w_count;
  assign bus.protocol_err  = r_protocol_err;
  assign bus.underflow_err = w_underflow;

endmodule
